// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-addressed data memory (dmem_unit).
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } mem_size_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } dmem_state_t;

   function automatic int unsigned size_bytes(input mem_size_t size);
      return 32'd1 << size;
   endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load data formatter: keeps the low N bytes of a little-endian read word and
// sign- or zero-extends them to DATA_W.
module dmem_load_align
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_W = 64
) (
   input  logic [DATA_W-1:0] raw,
   input  logic [1:0]        size,
   input  logic              sgn,
   output logic [DATA_W-1:0] data
);

   localparam int unsigned NB = DATA_W / 8;

   int unsigned nbytes;
   logic        sbit;

   always_comb begin
      nbytes = size_bytes(mem_size_t'(size));
      sbit   = 1'b0;
      // Sign bit is the top bit of the most significant byte actually loaded.
      for (int i = 0; i < NB; i++) begin
         if (i == nbytes - 1) sbit = sgn & raw[8*i+7];
      end
      data = '0;
      for (int i = 0; i < NB; i++) begin
         data[8*i +: 8] = (i < nbytes) ? raw[8*i +: 8] : {8{sbit}};
      end
   end

endmodule

// File: rtl/dmem_unit.sv
// Byte-addressed MEM-stage data memory with registered read path and
// valid/ready handshakes. Define DMEM_ALIGN_CHECK_EN to reject unaligned accesses.
module dmem_unit
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_W      = 64,
   parameter int unsigned ADDR_W      = 64,
   parameter int unsigned DEPTH_BYTES = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err
);

   localparam int unsigned NB    = DATA_W / 8;
   localparam int unsigned IDX_W = $clog2(DEPTH_BYTES);
   localparam int unsigned AW1   = ADDR_W + 1;

   logic [7:0] mem [DEPTH_BYTES] = '{default: 8'h00};

   dmem_state_t       state_q, state_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q;

   mem_size_t         size;
   int unsigned       nbytes;
   logic              accept;
   logic              size_bad;
   logic              range_bad;
   logic              align_bad;
   logic              req_err;
   logic [ADDR_W:0]   end_addr;
   logic [IDX_W-1:0]  base;
   logic [DATA_W-1:0] raw_word;
   logic [DATA_W-1:0] load_data;

   assign size      = mem_size_t'(req_size);
   assign nbytes    = size_bytes(size);
   assign req_ready = (state_q == ST_IDLE) || resp_ready;
   assign accept    = req_valid && req_ready;
   assign base      = req_addr[IDX_W-1:0];

   // Extra carry bit keeps addresses near the top of ADDR_W from wrapping into range.
   assign end_addr  = {1'b0, req_addr} + AW1'(nbytes);
   assign range_bad = end_addr > AW1'(DEPTH_BYTES);
   assign size_bad  = (nbytes * 8) > DATA_W;

`ifdef DMEM_ALIGN_CHECK_EN
   assign align_bad = |(req_addr[2:0] & 3'(nbytes - 1));
`else
   assign align_bad = 1'b0;
`endif

   assign req_err = size_bad | range_bad | align_bad;

   always_comb begin
      raw_word = '0;
      for (int i = 0; i < NB; i++) begin
         if (i < nbytes) raw_word[8*i +: 8] = mem[base + IDX_W'(i)];
      end
   end

   dmem_load_align #(
      .DATA_W (DATA_W)
   ) u_load_align (
      .raw  (raw_word),
      .size (req_size),
      .sgn  (req_signed),
      .data (load_data)
   );

   // Storage is not reset; a committed store survives a reset pulse.
   always_ff @(posedge clk) begin
      if (accept && req_we && !req_err) begin
         for (int i = 0; i < NB; i++) begin
            if (i < nbytes) mem[base + IDX_W'(i)] <= req_wdata[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (req_valid) state_d = ST_RESP;
         ST_RESP: if (resp_ready && !req_valid) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign rdata_d = (req_we || req_err) ? '0 : load_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            rdata_q <= rdata_d;
            err_q   <= req_err;
         end
      end
   end

   assign resp_valid = (state_q == ST_RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_unit.sv
// Self-checking bench for dmem_unit: byte-array reference model plus response queue,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dmem_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic        resp_err;

   always #5 clk = ~clk;

   dmem_unit u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   typedef struct {
      logic [63:0] rdata;
      logic        err;
   } resp_t;

   logic [7:0]  mm [1024];
   resp_t       exp_q [$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic        got_valid;
   logic [63:0] got_rdata;
   logic        got_err;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference: what an accepted request must return, applying its side effect to mm.
   task automatic model_req(input logic we, input logic [1:0] sz, input logic sg,
                            input logic [63:0] a, input logic [63:0] wd, output resp_t r);
      int          n;
      logic [64:0] e;
      logic [63:0] v;
      n = 1 << sz;
      e = {1'b0, a} + 65'(n);
      r.err   = (e > 65'd1024);
`ifdef DMEM_ALIGN_CHECK_EN
      if ((a % n) != 0) r.err = 1'b1;
`endif
      r.rdata = 64'd0;
      if (!r.err) begin
         if (we) begin
            for (int i = 0; i < n; i++) mm[int'(a[9:0]) + i] = wd[8*i +: 8];
         end else begin
            v = 64'd0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = mm[int'(a[9:0]) + i];
            if (sg && n < 8 && v[8*n-1]) begin
               for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
            end
            r.rdata = v;
         end
      end
   endtask

   // One clock: drive at negedge, compare outputs, advance the model for the coming edge.
   task automatic cycle(input logic v, input logic we, input logic [1:0] sz, input logic sg,
                        input logic [63:0] a, input logic [63:0] wd, input logic rr);
      logic  mready;
      resp_t r;
      @(negedge clk);
      req_valid  = v;
      req_we     = we;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      resp_ready = rr;
      #1;
      got_valid = resp_valid;
      got_rdata = resp_rdata;
      got_err   = resp_err;
      mready = (exp_q.size() == 0) || rr;
      check("resp_valid", 64'(resp_valid), 64'(exp_q.size() != 0));
      check("req_ready", 64'(req_ready), 64'(mready));
      if (exp_q.size() != 0) begin
         check("resp_rdata", resp_rdata, exp_q[0].rdata);
         check("resp_err", 64'(resp_err), 64'(exp_q[0].err));
         if (rr) void'(exp_q.pop_front());
      end
      if (v && mready) begin
         model_req(we, sz, sg, a, wd, r);
         exp_q.push_back(r);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0, 1'b1);
   endtask

   // Isolated transaction with a hand-computed expectation on top of the model.
   task automatic txn(input string name, input logic we, input logic [1:0] sz, input logic sg,
                      input logic [63:0] a, input logic [63:0] wd,
                      input logic exp_err, input logic [63:0] exp_rd);
      cycle(1'b1, we, sz, sg, a, wd, 1'b1);
      cycle(1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0, 1'b1);
      check({name, " valid"}, 64'(got_valid), 64'd1);
      check({name, " rdata"}, got_rdata, exp_rd);
      check({name, " err"}, 64'(got_err), 64'(exp_err));
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mm[i] = 8'h00;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_size   = 2'd0;
      req_signed = 1'b0;
      req_addr   = 64'd0;
      req_wdata  = 64'd0;
      resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset resp_valid", 64'(resp_valid), 64'd0);
      check("reset resp_rdata", resp_rdata, 64'd0);
      check("reset resp_err", 64'(resp_err), 64'd0);
      check("reset req_ready", 64'(req_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;

      txn("st_d_10", 1'b1, 2'd3, 1'b0, 64'h10, 64'h1122334455667788, 1'b0, 64'd0);
      txn("ld_d_10", 1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 1'b0, 64'h1122334455667788);
      txn("ld_bs_17", 1'b0, 2'd0, 1'b1, 64'h17, 64'd0, 1'b0, 64'h11);
      txn("st_b_17", 1'b1, 2'd0, 1'b0, 64'h17, 64'hAAAA_AAAA_AAAA_AA80, 1'b0, 64'd0);
      txn("ld_bs_80", 1'b0, 2'd0, 1'b1, 64'h17, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FF80);
      txn("ld_bu_80", 1'b0, 2'd0, 1'b0, 64'h17, 64'd0, 1'b0, 64'h80);
      txn("st_w_3fe", 1'b1, 2'd2, 1'b0, 64'h3FE, 64'hDEAD_BEEF, 1'b1, 64'd0);
      txn("ld_h_3fe", 1'b0, 2'd1, 1'b0, 64'h3FE, 64'd0, 1'b0, 64'd0);
      txn("ld_d_wrap", 1'b0, 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 1'b1, 64'd0);
`ifdef DMEM_ALIGN_CHECK_EN
      txn("ld_h_11", 1'b0, 2'd1, 1'b0, 64'h11, 64'd0, 1'b1, 64'd0);
`else
      txn("ld_h_11", 1'b0, 2'd1, 1'b0, 64'h11, 64'd0, 1'b0, 64'h6677);
`endif

      // Store then load of the same half on consecutive accepts.
      cycle(1'b1, 1'b1, 2'd1, 1'b0, 64'h20, 64'hBEEF, 1'b1);
      cycle(1'b1, 1'b0, 2'd1, 1'b0, 64'h20, 64'd0, 1'b1);
      cycle(1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0, 1'b1);
      check("b2b st->ld rdata", got_rdata, 64'hBEEF);
      idle(1);

      // Backpressure: response must hold while the next request waits.
      cycle(1'b1, 1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b0, 2'd0, 1'b0, 64'h10, 64'd0, 1'b0);
         check("bp req_ready", 64'(req_ready), 64'd0);
         check("bp held rdata", got_rdata, 64'h8022334455667788);
      end
      cycle(1'b1, 1'b0, 2'd0, 1'b0, 64'h10, 64'd0, 1'b1);
      cycle(1'b1, 1'b0, 2'd1, 1'b0, 64'h20, 64'd0, 1'b1);
      check("b2b resp 2", got_rdata, 64'h88);
      cycle(1'b1, 1'b0, 2'd0, 1'b1, 64'h17, 64'd0, 1'b1);
      check("b2b resp 3", got_rdata, 64'hBEEF);
      idle(2);

      // Reset while a response is pending.
      cycle(1'b1, 1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 1'b0);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      check("pre-reset resp_valid", 64'(resp_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      check("async reset resp_valid", 64'(resp_valid), 64'd0);
      check("async reset req_ready", 64'(req_ready), 64'd1);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      txn("ld_after_rst", 1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 1'b0, 64'h8022334455667788);

      for (int k = 0; k < 3000; k++) begin
         logic [63:0] a;
         int          r;
         r = $urandom_range(0, 99);
         if (r < 80)      a = 64'($urandom_range(0, 1023));
         else if (r < 95) a = 64'($urandom_range(1000, 1100));
         else             a = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
         cycle($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 40,
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a,
               {$urandom, $urandom}, $urandom_range(0, 99) < 70);
      end
      idle(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
